// File: rtl/gmii_tx_arb.sv
// Two-port round-robin GMII transmit arbiter: frames each granted byte stream with
// preamble/SFD, pads short frames, flags underrun/overlength with txer and enforces the IFG.
module gmii_tx_arb #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12,
    parameter int MIN_LEN      = 60,
    parameter int MAX_LEN      = 1514
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic [7:0] txd,
    output logic       txen,
    output logic       txer,
    output logic [1:0] grant
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, DRAIN, IFG} state_t;

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);

    state_t      state_r, state_nx_s;
    logic [15:0] tmr_r, tmr_nx_s;
    logic [10:0] cnt_r, cnt_nx_s, cnt_inc_s;
    logic [7:0]  byte_buf_r, byte_buf_nx_s;
    logic        buf_pend_r, buf_pend_nx_s;
    logic        err_pend_r, err_pend_nx_s;
    logic        seen_last_r, seen_last_nx_s;
    logic [1:0]  grant_r, grant_nx_s;
    logic        last_grant_r, last_grant_nx_s;
    logic [7:0]  txd_r, txd_nx_s;
    logic        txen_r, txen_nx_s, txer_r, txer_nx_s;
    logic        g_valid_s, g_last_s, rdy_en_s, pick1_s, done_s, acc_last_s;
    logic [7:0]  g_data_s;

    // Route the granted port's stream and gate its ready.
    always_comb begin
        if (grant_r[1]) begin
            g_valid_s = s1_valid;
            g_last_s  = s1_last;
            g_data_s  = s1_data;
        end else begin
            g_valid_s = s0_valid;
            g_last_s  = s0_last;
            g_data_s  = s0_data;
        end
        rdy_en_s = (state_r == SFD) || (state_r == DATA) || ((state_r == DRAIN) && !seen_last_r);
        s0_ready = grant_r[0] & rdy_en_s;
        s1_ready = grant_r[1] & rdy_en_s;
    end

    // Next-state and next-output logic; one payload byte is buffered for the 1-cycle latency.
    always_comb begin
        state_nx_s      = state_r;
        tmr_nx_s        = tmr_r;
        cnt_nx_s        = cnt_r;
        cnt_inc_s       = cnt_r + 11'd1;
        byte_buf_nx_s   = byte_buf_r;
        buf_pend_nx_s   = buf_pend_r;
        err_pend_nx_s   = err_pend_r;
        seen_last_nx_s  = seen_last_r;
        grant_nx_s      = grant_r;
        last_grant_nx_s = last_grant_r;
        txd_nx_s        = 8'h00;
        txen_nx_s       = 1'b0;
        txer_nx_s       = 1'b0;
        pick1_s         = 1'b0;
        done_s          = 1'b0;
        acc_last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    pick1_s         = s1_valid && (!s0_valid || !last_grant_r);
                    grant_nx_s      = pick1_s ? 2'b10 : 2'b01;
                    last_grant_nx_s = pick1_s;
                    cnt_nx_s        = 11'd0;
                    tmr_nx_s        = 16'd0;
                    buf_pend_nx_s   = 1'b0;
                    err_pend_nx_s   = 1'b0;
                    seen_last_nx_s  = 1'b0;
                    state_nx_s      = PRE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PRE: begin
                txd_nx_s  = 8'h55;
                txen_nx_s = 1'b1;
                if (tmr_r == PRE_LAST) begin
                    state_nx_s = SFD;
                    tmr_nx_s   = 16'd0;
                end else begin
                    tmr_nx_s = tmr_r + 16'd1;
                end
            end
            SFD, DATA: begin
                txd_nx_s  = (state_r == SFD) ? 8'hD5 : byte_buf_r;
                txen_nx_s = 1'b1;
                if (g_valid_s) begin
                    byte_buf_nx_s = g_data_s;
                    cnt_nx_s      = cnt_inc_s;
                    if (g_last_s) begin
                        state_nx_s    = PAD;
                        buf_pend_nx_s = 1'b1;
                    end else if (cnt_inc_s == MAX_L) begin
                        // Overlength: flush this byte, then flag the error.
                        state_nx_s    = DRAIN;
                        buf_pend_nx_s = 1'b1;
                        err_pend_nx_s = 1'b1;
                    end else begin
                        state_nx_s = DATA;
                    end
                end else begin
                    state_nx_s    = DRAIN;
                    buf_pend_nx_s = 1'b0;
                    err_pend_nx_s = 1'b1;
                end
            end
            PAD: begin
                txen_nx_s = 1'b1;
                if (buf_pend_r) begin
                    txd_nx_s      = byte_buf_r;
                    buf_pend_nx_s = 1'b0;
                    done_s        = (cnt_r >= MIN_L);
                end else begin
                    txd_nx_s = 8'h00;
                    cnt_nx_s = cnt_inc_s;
                    done_s   = (cnt_inc_s >= MIN_L);
                end
                if (done_s) begin
                    state_nx_s = IFG;
                    grant_nx_s = 2'b00;
                    tmr_nx_s   = 16'd0;
                end else begin
                    state_nx_s = PAD;
                end
            end
            DRAIN: begin
                acc_last_s = g_valid_s && g_last_s && !seen_last_r;
                if (buf_pend_r) begin
                    txd_nx_s      = byte_buf_r;
                    txen_nx_s     = 1'b1;
                    buf_pend_nx_s = 1'b0;
                end else if (err_pend_r) begin
                    txen_nx_s     = 1'b1;
                    txer_nx_s     = 1'b1;
                    err_pend_nx_s = 1'b0;
                end else begin
                    txen_nx_s = 1'b0;
                end
                if (acc_last_s) begin
                    seen_last_nx_s = 1'b1;
                end else begin
                    seen_last_nx_s = seen_last_r;
                end
                if ((seen_last_r || acc_last_s) && !(buf_pend_r && err_pend_r)) begin
                    state_nx_s = IFG;
                    grant_nx_s = 2'b00;
                    tmr_nx_s   = 16'd0;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            IFG: begin
                if (tmr_r == IFG_LAST) begin
                    state_nx_s = IDLE;
                    tmr_nx_s   = 16'd0;
                end else begin
                    tmr_nx_s = tmr_r + 16'd1;
                end
            end
            default: begin
                state_nx_s = IDLE;
                grant_nx_s = 2'b00;
            end
        endcase
    end

    // State and registered GMII outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_r      <= IDLE;
            tmr_r        <= 16'd0;
            cnt_r        <= 11'd0;
            byte_buf_r   <= 8'h00;
            buf_pend_r   <= 1'b0;
            err_pend_r   <= 1'b0;
            seen_last_r  <= 1'b0;
            grant_r      <= 2'b00;
            last_grant_r <= 1'b1;
            txd_r        <= 8'h00;
            txen_r       <= 1'b0;
            txer_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            tmr_r        <= tmr_nx_s;
            cnt_r        <= cnt_nx_s;
            byte_buf_r   <= byte_buf_nx_s;
            buf_pend_r   <= buf_pend_nx_s;
            err_pend_r   <= err_pend_nx_s;
            seen_last_r  <= seen_last_nx_s;
            grant_r      <= grant_nx_s;
            last_grant_r <= last_grant_nx_s;
            txd_r        <= txd_nx_s;
            txen_r       <= txen_nx_s;
            txer_r       <= txer_nx_s;
        end
    end

    assign txd   = txd_r;
    assign txen  = txen_r;
    assign txer  = txer_r;
    assign grant = grant_r;
endmodule

// File: tb/tb_gmii_tx_arb.sv
// Directed bench for gmii_tx_arb: handshake-aware byte sources on both ports and
// cycle-indexed expectations counted from the grant edge (edge 0).
module tb_gmii_tx_arb;
    logic       sys_clk = 1'b0;
    logic       reset;
    logic [7:0] s0_data, s1_data;
    logic       s0_valid, s0_last, s0_ready;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] txd;
    logic       txen, txer;
    logic [1:0] grant;

    int          n_chk = 0;
    int          n_fail = 0;
    int          src_len[2], src_idx[2], src_hole_at[2], src_hole_left[2];
    logic [7:0]  src_base[2];
    bit          src_on[2], hole_now[2], hs[2];
    logic [31:0] e;

    gmii_tx_arb dut (
        .sys_clk(sys_clk), .reset(reset),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
        .txd(txd), .txen(txen), .txer(txer), .grant(grant)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] ev(input logic er, input logic en, input logic [7:0] d);
        return {22'd0, er, en, d};
    endfunction

    function automatic logic [31:0] outv();
        return {22'd0, txer, txen, txd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        s0_valid = src_on[0] && (src_idx[0] < src_len[0]) && !hole_now[0];
        s0_data  = src_base[0] + 8'(src_idx[0]);
        s0_last  = (src_idx[0] == src_len[0] - 1);
        s1_valid = src_on[1] && (src_idx[1] < src_len[1]) && !hole_now[1];
        s1_data  = src_base[1] + 8'(src_idx[1]);
        s1_last  = (src_idx[1] == src_len[1] - 1);
    endtask

    task automatic start_src(input int p, input logic [7:0] base, input int len,
                             input int hole_at, input int hole_len);
        src_on[p] = 1'b1;
        src_base[p] = base;
        src_len[p] = len;
        src_idx[p] = 0;
        src_hole_at[p] = hole_at;
        src_hole_left[p] = hole_len;
        hole_now[p] = 1'b0;
        drive_src();
    endtask

    // One clock: record handshakes before the edge, advance sources just after it.
    task automatic cyc();
        @(negedge sys_clk);
        hs[0] = s0_valid && s0_ready;
        hs[1] = s1_valid && s1_ready;
        @(posedge sys_clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (hs[p]) src_idx[p]++;
            hole_now[p] = (src_idx[p] == src_hole_at[p]) && (src_hole_left[p] > 0);
            if (hole_now[p]) src_hole_left[p]--;
        end
        drive_src();
    endtask

    task automatic rst();
        src_on[0] = 1'b0;
        src_on[1] = 1'b0;
        drive_src();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            src_on[p] = 1'b0; src_len[p] = 0; src_idx[p] = 0; src_base[p] = 8'h00;
            src_hole_at[p] = -1; src_hole_left[p] = 0; hole_now[p] = 1'b0;
        end
        drive_src();
        cyc();
        cyc();
        chk("rst_out", outv(), ev(1'b0, 1'b0, 8'h00));
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rdy0", 32'(s0_ready), 32'd0);
        chk("rst_rdy1", 32'(s1_ready), 32'd0);
        reset = 1'b0;

        // Port 0, 64 bytes 0x01..0x40
        start_src(0, 8'h01, 64, -1, 0);
        cyc();
        chk("t1_grant0", 32'(grant), 32'd1);
        chk("t1_out0", outv(), ev(1'b0, 1'b0, 8'h00));
        for (int k = 1; k <= 84; k++) begin
            cyc();
            if (k <= 7)       e = ev(1'b0, 1'b1, 8'h55);
            else if (k == 8)  e = ev(1'b0, 1'b1, 8'hD5);
            else if (k <= 72) e = ev(1'b0, 1'b1, 8'(k - 8));
            else              e = ev(1'b0, 1'b0, 8'h00);
            chk($sformatf("t1_out_%0d", k), outv(), e);
            if (k == 20) chk("t1_rdy1_off", 32'(s1_ready), 32'd0);
            if (k == 73) chk("t1_grant_ifg", 32'(grant), 32'd0);
        end

        // Contention after reset: port 0, then port 1, then port 0 again
        rst();
        start_src(0, 8'h80, 60, -1, 0);
        start_src(1, 8'h10, 60, -1, 0);
        cyc();
        chk("t2_grant_first", 32'(grant), 32'd1);
        for (int k = 1; k <= 162; k++) begin
            cyc();
            if (k == 9)   chk("t2_p0_byte1", outv(), ev(1'b0, 1'b1, 8'h80));
            if (k == 80)  chk("t2_grant_idle", 32'(grant), 32'd0);
            if (k == 81)  chk("t2_grant_p1", 32'(grant), 32'd2);
            if (k == 90)  chk("t2_p1_byte1", outv(), ev(1'b0, 1'b1, 8'h10));
            if (k == 155) begin
                start_src(0, 8'h80, 60, -1, 0);
                start_src(1, 8'h10, 60, -1, 0);
            end
            if (k == 161) chk("t2_grant_idle2", 32'(grant), 32'd0);
            if (k == 162) chk("t2_grant_rr", 32'(grant), 32'd1);
        end
        rst();

        // Port 1, 20 bytes: padded to 60
        start_src(1, 8'hA0, 20, -1, 0);
        cyc();
        chk("t3_grant", 32'(grant), 32'd2);
        for (int k = 1; k <= 80; k++) begin
            cyc();
            if (k <= 7)       e = ev(1'b0, 1'b1, 8'h55);
            else if (k == 8)  e = ev(1'b0, 1'b1, 8'hD5);
            else if (k <= 28) e = ev(1'b0, 1'b1, 8'hA0 + 8'(k - 9));
            else if (k <= 68) e = ev(1'b0, 1'b1, 8'h00);
            else              e = ev(1'b0, 1'b0, 8'h00);
            chk($sformatf("t3_out_%0d", k), outv(), e);
        end

        // Port 0 underrun after byte 10 of 100
        start_src(0, 8'h01, 100, 10, 3);
        cyc();
        chk("t4_grant", 32'(grant), 32'd1);
        for (int k = 1; k <= 122; k++) begin
            cyc();
            if (k <= 7)       e = ev(1'b0, 1'b1, 8'h55);
            else if (k == 8)  e = ev(1'b0, 1'b1, 8'hD5);
            else if (k <= 18) e = ev(1'b0, 1'b1, 8'(k - 8));
            else if (k == 19) e = ev(1'b1, 1'b1, 8'h00);
            else              e = ev(1'b0, 1'b0, 8'h00);
            chk($sformatf("t4_out_%0d", k), outv(), e);
            if (k == 20)  chk("t4_drain_rdy", 32'(s0_ready), 32'd1);
            if (k == 109) chk("t4_drain_grant", 32'(grant), 32'd1);
            if (k == 111) chk("t4_ifg_rdy", 32'(s0_ready), 32'd0);
            if (k == 111) chk("t4_ifg_grant", 32'(grant), 32'd0);
        end

        // Reset during byte 30, port 1 pending
        start_src(0, 8'h01, 100, -1, 0);
        cyc();
        for (int k = 1; k <= 37; k++) cyc();
        chk("t5_byte29", outv(), ev(1'b0, 1'b1, 8'h1D));
        start_src(1, 8'h40, 60, -1, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t5_rst_out", outv(), ev(1'b0, 1'b0, 8'h00));
        chk("t5_rst_grant", 32'(grant), 32'd0);
        chk("t5_rst_rdy0", 32'(s0_ready), 32'd0);
        chk("t5_rst_rdy1", 32'(s1_ready), 32'd0);
        cyc();
        chk("t5_regrant", 32'(grant), 32'd1);
        chk("t5_regrant_out", outv(), ev(1'b0, 1'b0, 8'h00));
        rst();

        // Port 0, 1600 bytes with no early last: overlength
        start_src(0, 8'h01, 1600, -1, 0);
        cyc();
        chk("t6_grant", 32'(grant), 32'd1);
        for (int k = 1; k <= 1620; k++) begin
            cyc();
            if (k == 1521) chk("t6_b1513", outv(), ev(1'b0, 1'b1, 8'hE9));
            if (k == 1522) chk("t6_b1514", outv(), ev(1'b0, 1'b1, 8'hEA));
            if (k == 1523) chk("t6_txer", outv(), ev(1'b1, 1'b1, 8'h00));
            if (k == 1524) chk("t6_drain_out", outv(), ev(1'b0, 1'b0, 8'h00));
            if (k == 1524) chk("t6_drain_rdy", 32'(s0_ready), 32'd1);
            if (k == 1606) chk("t6_grant_drain", 32'(grant), 32'd1);
            if (k == 1607) chk("t6_grant_ifg", 32'(grant), 32'd0);
            if (k == 1608) chk("t6_ifg_rdy", 32'(s0_ready), 32'd0);
            if (k == 1619) chk("t6_ifg_out", outv(), ev(1'b0, 1'b0, 8'h00));
            if (k == 1620) chk("t6_idle_grant", 32'(grant), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
